// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment driver with per-frame snapshot, blink and anti-ghost blanking.
// Latency: seg/dp/dig_sel are registered one cycle after the pre/idx state; frame_tick is same-cycle.
// Backpressure: none; free-running scan, inputs sampled only at frame snapshots.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [5:0] blink_mask,
    input  logic [5:0] dp_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;
    logic              first_q;
    logic [5:0][3:0]   sh_dig_q, sh_dig_d;
    logic [5:0]        sh_blink_q, sh_blink_d;
    logic [5:0]        sh_dp_q, sh_dp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [5:0]        dig_sel_q, dig_sel_d;

    logic              pre_last;
    logic              snap;
    logic [3:0]        cur_dig;
    logic              cur_blink;
    logic              cur_dp;
    logic              blank;
    logic              dark;

    // Glyph table; codes 10..14 render a dash, 15 renders nothing.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            4'd15:   decode = 7'h00;
            default: decode = 7'b1000000;
        endcase
    endfunction

    // Scan counters, frame snapshot, blink phase and next registered outputs.
    always_comb begin
        pre_last    = (pre_q == PW'(SCAN_DIV - 1));
        // first_q marks the first cycle out of reset so the opening frame has fresh data.
        snap        = first_q | (pre_last & (idx_q == 3'd5));

        pre_d       = pre_last ? '0 : pre_q + PW'(1);
        idx_d       = idx_q;
        if (pre_last) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        sh_dig_d    = sh_dig_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;
        if (snap) begin
            sh_dig_d   = {d5, d4, d3, d2, d1, d0};
            sh_blink_d = blink_mask;
            sh_dp_d    = dp_mask;
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        cur_dig   = 4'd0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        case (idx_q)
            3'd0: begin cur_dig = sh_dig_q[0]; cur_blink = sh_blink_q[0]; cur_dp = sh_dp_q[0]; end
            3'd1: begin cur_dig = sh_dig_q[1]; cur_blink = sh_blink_q[1]; cur_dp = sh_dp_q[1]; end
            3'd2: begin cur_dig = sh_dig_q[2]; cur_blink = sh_blink_q[2]; cur_dp = sh_dp_q[2]; end
            3'd3: begin cur_dig = sh_dig_q[3]; cur_blink = sh_blink_q[3]; cur_dp = sh_dp_q[3]; end
            3'd4: begin cur_dig = sh_dig_q[4]; cur_blink = sh_blink_q[4]; cur_dp = sh_dp_q[4]; end
            3'd5: begin cur_dig = sh_dig_q[5]; cur_blink = sh_blink_q[5]; cur_dp = sh_dp_q[5]; end
            default: ;
        endcase

        // Slot start is fully dark so the previous digit's segments cannot ghost.
        blank = (pre_q < PW'(BLANK_CYC));
        // A blinking digit stays selected but shows nothing in the off phase.
        dark  = blink_ph_q & cur_blink;

        dig_sel_d = blank ? 6'b111111 : ~(6'b000001 << idx_q);
        seg_d     = (blank | dark) ? 7'h00 : decode(cur_dig);
        dp_d      = (blank | dark) ? 1'b0  : cur_dp;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            first_q     <= 1'b1;
            sh_dig_q    <= '0;
            sh_blink_q  <= '0;
            sh_dp_q     <= '0;
            seg_q       <= 7'h00;
            dp_q        <= 1'b0;
            dig_sel_q   <= 6'b111111;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            first_q     <= 1'b0;
            sh_dig_q    <= sh_dig_d;
            sh_blink_q  <= sh_blink_d;
            sh_dp_q     <= sh_dp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_sel_q   <= dig_sel_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_sel    = dig_sel_q;
    // Pulses in the cycle whose closing edge captures the snapshot.
    assign frame_tick = snap & ~rst;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [5:0] blink_mask, dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_sel;
    logic       frame_tick;

    seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .blink_mask(blink_mask), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] nd;
        logic [5:0]  nbm;
        logic [5:0]  ndp;
        logic [41:0] es;
        logic [5:0]  edp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("dig_sel_onehot", ($countones(~dig_sel) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic logic [23:0] dg(input logic [3:0] a0, a1, a2, a3, a4, a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [41:0] sg(input logic [6:0] s0, s1, s2, s3, s4, s5);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic apply(input logic [23:0] nd, input logic [5:0] nbm, input logic [5:0] ndp);
        d0 = nd[3:0];   d1 = nd[7:4];   d2 = nd[11:8];
        d3 = nd[15:12]; d4 = nd[19:16]; d5 = nd[23:20];
        blink_mask = nbm;
        dp_mask    = ndp;
    endtask

    task automatic set_row(input int k, input logic [23:0] nd, input logic [5:0] nbm,
                           input logic [5:0] ndp, input logic [41:0] es, input logic [5:0] edp);
        tbl[k].nd  = nd;
        tbl[k].nbm = nbm;
        tbl[k].ndp = ndp;
        tbl[k].es  = es;
        tbl[k].edp = edp;
    endtask

    // One 24-cycle output window: per slot one dark cycle then three lit cycles;
    // the next snapshot tick lands in window cycle 22. Optional input update mid-slot-3.
    task automatic check_frame(input int fr, input logic [41:0] es, input logic [5:0] edp,
                               input logic [23:0] nd, input logic [5:0] nbm, input logic [5:0] ndp);
        logic [5:0] one;
        logic [5:0] exp_sel;
        logic [6:0] exp_seg;
        logic       exp_dp;
        one = 6'b000001;
        for (int j = 0; j < 24; j++) begin
            step();
            if (j % 4 == 0) begin
                exp_sel = 6'b111111;
                exp_seg = 7'h00;
                exp_dp  = 1'b0;
            end else begin
                exp_sel = ~(one << (j / 4));
                exp_seg = es[(j / 4) * 7 +: 7];
                exp_dp  = edp[j / 4];
            end
            chk($sformatf("f%0d_c%0d_dig_sel", fr, j), {26'd0, dig_sel}, {26'd0, exp_sel});
            chk($sformatf("f%0d_c%0d_seg", fr, j), {25'd0, seg}, {25'd0, exp_seg});
            chk($sformatf("f%0d_c%0d_dp", fr, j), {31'd0, dp}, {31'd0, exp_dp});
            chk($sformatf("f%0d_c%0d_tick", fr, j), {31'd0, frame_tick}, (j == 22) ? 32'd1 : 32'd0);
            if (j == 13) apply(nd, nbm, ndp);
        end
    endtask

    initial begin
        logic [23:0] base, d2_9, edit, mix, fresh;
        logic [41:0] s_base, s_9;
        base  = dg(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        d2_9  = dg(4'd0, 4'd1, 4'd9, 4'd3, 4'd4, 4'd5);
        edit  = dg(4'd0, 4'd1, 4'd9, 4'd3, 4'hF, 4'hC);
        mix   = dg(4'd8, 4'hA, 4'hE, 4'd7, 4'd6, 4'd1);
        fresh = dg(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
        s_base = sg(7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D);
        s_9    = sg(7'h3F, 7'h06, 7'h6F, 7'h4F, 7'h66, 7'h6D);

        // Row k: expected display of frame k, then inputs applied mid-frame (seen in frame k+1).
        // Blink phase of frame k (BLINK_FRAMES=2) is ((k+1)/2)%2.
        set_row(0,  base, 6'h00, 6'h00, s_base, 6'h00);
        set_row(1,  d2_9, 6'h00, 6'h00, s_base, 6'h00);
        set_row(2,  d2_9, 6'b000011, 6'h00, s_9, 6'h00);
        set_row(3,  d2_9, 6'b000011, 6'h00, s_9, 6'h00);
        set_row(4,  d2_9, 6'b000011, 6'h00, s_9, 6'h00);
        set_row(5,  d2_9, 6'b000011, 6'h00, sg(7'h00, 7'h00, 7'h6F, 7'h4F, 7'h66, 7'h6D), 6'h00);
        set_row(6,  d2_9, 6'b000011, 6'h00, sg(7'h00, 7'h00, 7'h6F, 7'h4F, 7'h66, 7'h6D), 6'h00);
        set_row(7,  edit, 6'h00, 6'b000100, s_9, 6'h00);
        set_row(8,  mix, 6'h00, 6'b100001, sg(7'h3F, 7'h06, 7'h6F, 7'h4F, 7'h00, 7'h40), 6'b000100);
        set_row(9,  mix, 6'b100001, 6'b100001, sg(7'h7F, 7'h40, 7'h40, 7'h07, 7'h7D, 7'h06), 6'b100001);
        set_row(10, mix, 6'b100001, 6'b100001, sg(7'h00, 7'h40, 7'h40, 7'h07, 7'h7D, 7'h00), 6'h00);

        // Reset held for three cycles: everything dark, no tick.
        rst = 1'b1;
        apply(base, 6'h00, 6'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d_dig_sel", i), {26'd0, dig_sel}, 32'h3F);
            chk($sformatf("rst%0d_seg", i), {25'd0, seg}, 32'h00);
            chk($sformatf("rst%0d_dp", i), {31'd0, dp}, 32'd0);
            chk($sformatf("rst%0d_tick", i), {31'd0, frame_tick}, 32'd0);
        end

        // First cycle after release takes the opening snapshot.
        rst = 1'b0;
        #1;
        chk("release_tick", {31'd0, frame_tick}, 32'd1);

        for (int k = 0; k < 11; k++) begin
            check_frame(k, tbl[k].es, tbl[k].edp, tbl[k].nd, tbl[k].nbm, tbl[k].ndp);
        end

        // Reset while digit 3 is lit, then restart with new digits.
        for (int j = 0; j < 13; j++) step();
        step();
        chk("pre_rst_slot3_sel", {26'd0, dig_sel}, 32'h37);
        rst = 1'b1;
        apply(fresh, 6'h00, 6'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("midrst%0d_dig_sel", i), {26'd0, dig_sel}, 32'h3F);
            chk($sformatf("midrst%0d_seg", i), {25'd0, seg}, 32'h00);
            chk($sformatf("midrst%0d_tick", i), {31'd0, frame_tick}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rerelease_tick", {31'd0, frame_tick}, 32'd1);
        check_frame(11, sg(7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66), 6'h00, fresh, 6'h00, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
